// File: rtl/vx_raster_stamp_csr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vx_raster_stamp_csr_pkg: raster stamp/CSR types and shared constants.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vx_raster_stamp_csr_pkg;

    localparam int NUM_THREADS      = 4;
    localparam int NUM_WARPS        = 8;
    localparam int NW_BITS          = 3;
    localparam int UUID_BITS        = 44;
    localparam int PERF_CTR_BITS    = 44;
    localparam int CSR_ADDR_BITS    = 12;
    localparam int RASTER_DIM_BITS  = 14;
    localparam int RASTER_MASK_BITS = 4;

    localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_POS_MASK = 12'h7C0;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_X = 12'h7C1;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_Y = 12'h7C2;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_Z = 12'h7C3;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_POP      = 12'h7C4;
    localparam int CSR_RASTER_COUNT    = 4;
    localparam int CSR_RASTER_IDX_BITS = $clog2(CSR_RASTER_COUNT);

    typedef struct packed {
        logic [RASTER_DIM_BITS-1:0]  pos_x;
        logic [RASTER_DIM_BITS-1:0]  pos_y;
        logic [RASTER_MASK_BITS-1:0] mask;
        logic [2:0][31:0]            bcoords;
    } raster_stamp_t;

    typedef struct packed {
        logic [31:0]      pos_mask;
        logic [2:0][31:0] bcoords;
    } raster_csrs_t;

    function automatic raster_csrs_t stamp_to_csrs(input raster_stamp_t s);
        raster_csrs_t c;
        c.pos_mask = {s.pos_y, s.pos_x, s.mask};
        c.bcoords  = s.bcoords;
        return c;
    endfunction

    // Word 0 is pos_mask; words 1..3 are the barycentric coordinates in order.
    function automatic logic [31:0] csrs_word(input raster_csrs_t c,
                                              input logic [CSR_RASTER_IDX_BITS-1:0] idx);
        if (idx == '0)
            return c.pos_mask;
        return c.bcoords[idx - CSR_RASTER_IDX_BITS'(1)];
    endfunction

endpackage
`default_nettype wire

// File: rtl/VX_gpu_csr_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | VX_gpu_csr_if: per-lane CSR read/write access bundle.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface VX_gpu_csr_if #(
    parameter int NUM_LANES = vx_raster_stamp_csr_pkg::NUM_THREADS
);
    logic                                              read_enable;
    logic [vx_raster_stamp_csr_pkg::CSR_ADDR_BITS-1:0] read_addr;
    logic [vx_raster_stamp_csr_pkg::NW_BITS-1:0]       read_wid;
    logic [NUM_LANES-1:0][31:0]                        read_data;

    logic                                              write_enable;
    logic [vx_raster_stamp_csr_pkg::CSR_ADDR_BITS-1:0] write_addr;
    logic [vx_raster_stamp_csr_pkg::NW_BITS-1:0]       write_wid;
    logic [NUM_LANES-1:0][31:0]                        write_data;

    modport master (
        output read_enable, read_addr, read_wid,
        input  read_data,
        output write_enable, write_addr, write_wid, write_data
    );

    modport slave (
        input  read_enable, read_addr, read_wid,
        output read_data,
        input  write_enable, write_addr, write_wid, write_data
    );
endinterface
`default_nettype wire

// File: rtl/vx_raster_stamp_csr_dp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vx_raster_stamp_csr_dp_ram: LUTRAM, one sync write port, one async read.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vx_raster_stamp_csr_dp_ram #(
    parameter int DATAW = 128,
    parameter int SIZE  = 16,
    parameter int ADDRW = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [ADDRW-1:0] i_waddr,
    input  logic [DATAW-1:0] i_wdata,
    input  logic [ADDRW-1:0] i_raddr,
    output logic [DATAW-1:0] o_rdata
);
    logic [DATAW-1:0] r_mem [SIZE];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/vx_raster_stamp_csr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vx_raster_stamp_csr: per-warp stamp queues exposed through raster CSRs.    |
// | Optional perf counters: define RASTER_STAMP_PERF_EN. Revision: 1.0         |
// +----------------------------------------------------------------------------+
module vx_raster_stamp_csr
    import vx_raster_stamp_csr_pkg::*;
#(
    parameter int CORE_ID   = 0,
    parameter int NUM_LANES = NUM_THREADS,
    parameter int DEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          write_valid,
    output logic                          write_ready,
    input  logic [UUID_BITS-1:0]          write_uuid,
    input  logic [NW_BITS-1:0]            write_wid,
    input  logic [NUM_LANES-1:0]          write_tmask,
    input  raster_stamp_t [NUM_LANES-1:0] write_data,
    VX_gpu_csr_if.slave                   raster_csr_if,
    output logic [NUM_WARPS-1:0]          stamp_avail
`ifdef RASTER_STAMP_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]      perf_stalls,
    output logic [PERF_CTR_BITS-1:0]      perf_pops
`endif
);
    localparam int PTRW  = $clog2(DEPTH);
    localparam int CNTW  = PTRW + 1;
    localparam int ADDRW = NW_BITS + PTRW;
    localparam int SIZE  = NUM_WARPS * DEPTH;

    logic [PTRW-1:0]      r_rd_ptr [NUM_WARPS];
    logic [PTRW-1:0]      r_wr_ptr [NUM_WARPS];
    logic [CNTW-1:0]      r_count  [NUM_WARPS];
    logic [NUM_LANES-1:0] r_tmask  [SIZE];

    logic                        w_push;
    logic                        w_pop;
    logic [NW_BITS-1:0]          w_pop_wid;
    logic [NUM_WARPS-1:0]        w_push_sel;
    logic [NUM_WARPS-1:0]        w_pop_sel;
    logic [ADDRW-1:0]            w_waddr;
    logic [ADDRW-1:0]            w_raddr;
    logic [NW_BITS-1:0]          w_rd_wid;
    logic                        w_rd_nonempty;
    logic [NUM_LANES-1:0]        w_rd_tmask;
    logic [CSR_RASTER_IDX_BITS-1:0] w_rd_idx;
    raster_csrs_t                w_rdata [NUM_LANES];
    logic [NUM_LANES-1:0][31:0]  w_read_data;
    logic                        w_unused;

    // A full queue never accepts a push, even if the same warp pops this cycle.
    assign write_ready = (r_count[write_wid] < CNTW'(DEPTH));
    assign w_push      = !reset && write_valid && write_ready;
    assign w_pop_wid   = raster_csr_if.write_wid;
    assign w_pop       = !reset && raster_csr_if.write_enable
                         && (raster_csr_if.write_addr == CSR_RASTER_POP)
                         && (r_count[w_pop_wid] != '0);
    assign w_waddr     = {write_wid, r_wr_ptr[write_wid]};

    always_comb begin
        w_push_sel = '0;
        w_pop_sel  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_push_sel[w] = w_push && (write_wid == NW_BITS'(w));
            w_pop_sel[w]  = w_pop && (w_pop_wid == NW_BITS'(w));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_rd_ptr[w] <= '0;
                r_wr_ptr[w] <= '0;
                r_count[w]  <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (w_push_sel[w])
                    r_wr_ptr[w] <= r_wr_ptr[w] + PTRW'(1);
                if (w_pop_sel[w])
                    r_rd_ptr[w] <= r_rd_ptr[w] + PTRW'(1);
                if (w_push_sel[w] && !w_pop_sel[w])
                    r_count[w] <= r_count[w] + CNTW'(1);
                else if (!w_push_sel[w] && w_pop_sel[w])
                    r_count[w] <= r_count[w] - CNTW'(1);
            end
        end
    end

    // Lane masks are payload storage: not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_push)
            r_tmask[w_waddr] <= write_tmask;
    end

    assign w_rd_wid      = raster_csr_if.read_wid;
    assign w_raddr       = {w_rd_wid, r_rd_ptr[w_rd_wid]};
    assign w_rd_nonempty = (r_count[w_rd_wid] != '0);
    assign w_rd_tmask    = r_tmask[w_raddr];
    assign w_rd_idx      = raster_csr_if.read_addr[CSR_RASTER_IDX_BITS-1:0];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        vx_raster_stamp_csr_dp_ram #(
            .DATAW ($bits(raster_csrs_t)),
            .SIZE  (SIZE),
            .ADDRW (ADDRW)
        ) u_ram (
            .clk     (clk),
            .i_we    (w_push),
            .i_waddr (w_waddr),
            .i_wdata (stamp_to_csrs(write_data[i])),
            .i_raddr (w_raddr),
            .o_rdata (w_rdata[i])
        );
    end

    always_comb begin
        w_read_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_rd_nonempty && w_rd_tmask[i])
                w_read_data[i] = csrs_word(w_rdata[i], w_rd_idx);
        end
    end

    assign raster_csr_if.read_data = w_read_data;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_avail
        assign stamp_avail[w] = (r_count[w] != '0);
    end

`ifdef RASTER_STAMP_PERF_EN
    logic [PERF_CTR_BITS-1:0] r_perf_stalls;
    logic [PERF_CTR_BITS-1:0] r_perf_pops;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stalls <= '0;
            r_perf_pops   <= '0;
        end else begin
            if (write_valid && !write_ready)
                r_perf_stalls <= r_perf_stalls + PERF_CTR_BITS'(1);
            if (w_pop)
                r_perf_pops <= r_perf_pops + PERF_CTR_BITS'(1);
        end
    end

    assign perf_stalls = r_perf_stalls;
    assign perf_pops   = r_perf_pops;
`endif

    // Trace-only and don't-care inputs.
    assign w_unused = ^{raster_csr_if.read_enable,
                        raster_csr_if.read_addr[CSR_ADDR_BITS-1:CSR_RASTER_IDX_BITS],
                        raster_csr_if.write_data, write_uuid, (CORE_ID != 0)};

endmodule
`default_nettype wire

// File: doc/vx_raster_stamp_csr.md
VX_RASTER_STAMP_CSR -- requirements
Module: VX_raster_stamp_csr

Interface
REQ-001 SHALL have parameter CORE_ID, default 0, core index used in trace output only.
REQ-002 SHALL have parameter NUM_LANES, default `NUM_THREADS, stamp lanes per warp entry.
REQ-003 SHALL have parameter DEPTH, default 2, stamp entries queued per warp (power of two, >=2).
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: write_valid  in  1  stamp push request; write_ready  out  1  push accepted when high with write_valid.
REQ-006 SHALL have ports: write_uuid  in  `UP(`UUID_BITS)  trace tag; write_wid  in  `UP(`NW_BITS)  target warp; write_tmask  in  NUM_LANES  valid lanes.
REQ-007 SHALL have port write_data  in  NUM_LANES x raster_stamp_t  per-lane stamp.
REQ-008 SHALL have port raster_csr_if  VX_gpu_csr_if.slave  CSR read/write access.
REQ-009 SHALL have port stamp_avail  out  `NUM_WARPS  per-warp non-empty flag.

Function
REQ-010 SHALL keep one circular queue of DEPTH entries per warp; entry = NUM_LANES raster_csrs_t words + tmask.
REQ-011 SHALL assert write_ready iff count[write_wid] < DEPTH; no same-cycle pop bypass.
REQ-012 SHALL, on write_valid && write_ready, store {pos_y,pos_x,mask} into pos_mask and bcoords per lane, store write_tmask, advance wr_ptr[wid] modulo DEPTH, increment count.
REQ-013 SHALL return head entry field `read_addr[CLOG2(`CSR_RASTER_COUNT)-1:0]` of read_wid on read_data combinationally (zero latency).
REQ-014 SHALL return 0 on lanes whose stored tmask bit is 0 and on all lanes when read_wid queue is empty.
REQ-015 SHALL pop head of write_wid when raster_csr_if.write_enable && write_addr == `CSR_RASTER_POP; write_data ignored.
REQ-016 SHALL ignore a pop on an empty queue (count stays 0, pointers unchanged).
REQ-017 SHALL, on push and pop to same warp same cycle, perform both; count unchanged.
REQ-018 SHALL make a read in the pop cycle see the pre-pop head; a read in the push cycle sees pre-push state.
REQ-019 SHALL drive stamp_avail[w] = (count[w] != 0), registered state only.
REQ-020 SHALL ignore CSR writes to addresses other than `CSR_RASTER_POP.

Reset
REQ-021 SHALL clear all counts, rd_ptr and wr_ptr to 0 on reset; stamp_avail = 0, write_ready = 1 after reset.
REQ-022 SHALL discard queued stamps when reset asserts mid-operation; storage contents are not reset.
REQ-023 SHALL ignore push and pop in any cycle with reset high.

Configuration
REQ-024 SHALL, with RASTER_STAMP_PERF_EN defined, add outputs perf_stalls and perf_pops (each `PERF_CTR_BITS), counting write_valid && !write_ready cycles and effective pops, cleared by reset.
REQ-025 SHALL, without RASTER_STAMP_PERF_EN, omit those ports and counters entirely.

Structure
REQ-026 SHALL take raster_stamp_t, raster_csrs_t and `CSR_RASTER_POP from the shared raster package/define header.
REQ-027 SHALL instantiate one VX_dp_ram (LUTRAM) per lane, SIZE `NUM_WARPS*DEPTH, address {wid, ptr}; tmask in a separate flop array.
REQ-028 SHALL keep per-warp pointer/count logic in this module; no further sub-module.

Verification
REQ-029 Reset, then push wid=1 tmask=0xF pos_x=3 pos_y=5 mask=0xA -> stamp_avail=0b0010, read pos_mask lane0 = {5,3,0xA}.
REQ-030 Push wid=0 DEPTH times with no pop -> write_ready=0 on next push to wid=0, write_ready=1 for wid=2.
REQ-031 Push A then B to wid=2, pop once -> read returns B; pop again -> stamp_avail[2]=0, reads return 0.
REQ-032 Full wid=3 with simultaneous push and pop -> push rejected, pop taken, count=DEPTH-1 next cycle.
REQ-033 Push tmask=0x5 -> lanes 1,3 read 0; pop on empty wid=4 -> no state change, perf_pops unchanged.
REQ-034 Reset asserted with wid=0 holding 2 entries -> stamp_avail=0 and write_ready=1 next cycle.
